// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared frame constants, controller state type and checksum helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_ADDR = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4,
        ST_EXEC     = 3'd5,
        ST_RD_WAIT  = 3'd6,
        ST_TX       = 3'd7
    } frame_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl_if
// Brief    : Receiver, register-bus, transmitter and status signals of the
//            frame controller; master is the controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_ctrl_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_rd_valid;
    logic [7:0] reg_rdata;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       busy;
    logic       err_chk;
    logic       err_timeout;
    logic       rx_drop;

    modport master (
        input  rx_valid, rx_data, reg_rd_valid, reg_rdata, tx_ready,
        output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_valid, tx_data,
               busy, err_chk, err_timeout, rx_drop
    );

    modport slave (
        output rx_valid, rx_data, reg_rd_valid, reg_rdata, tx_ready,
        input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_valid, tx_data,
               busy, err_chk, err_timeout, rx_drop
    );

endinterface
`default_nettype wire

// File: rtl/uart_resp_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_resp_seq
// Brief    : 4-entry response buffer (length 1 or 4) streamed out over a
//            valid/ready byte handshake; done marks acceptance of the last byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_resp_seq (
    input  wire             clk,
    input  wire             rst,
    input  wire             load,
    input  wire             load_len4,
    input  wire [3:0][7:0]  load_bytes,
    input  wire             tx_ready,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    output logic            done
);

    logic [3:0][7:0] buf_q,   buf_d;
    logic            len4_q,  len4_d;
    logic [1:0]      idx_q,   idx_d;
    logic            valid_q, valid_d;
    logic            w_last;

    assign w_last   = len4_q ? (idx_q == 2'd3) : 1'b1;
    assign tx_valid = valid_q;
    assign tx_data  = buf_q[idx_q];
    assign done     = valid_q && tx_ready && w_last;

    always_comb begin
        buf_d   = buf_q;
        len4_d  = len4_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            buf_d   = load_bytes;
            len4_d  = load_len4;
            idx_d   = 2'd0;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            if (w_last) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            len4_q  <= 1'b0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            len4_q  <= len4_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Brief    : Parses SYNC/CMD/ADDR/DATA/CHK frames from the UART receiver,
//            issues register strobes and sequences the response bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter int RD_TIMEOUT  = 16
) (
    input  wire               clk,
    input  wire               rst,
    uart_frame_ctrl_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] c_tmo_max = TW'(TIMEOUT_CYC);
    localparam logic [RW-1:0] c_rd_last = RW'(RD_TIMEOUT - 1);

    frame_state_t    state_q,   state_d;
    logic [7:0]      cmd_q,     cmd_d;
    logic [7:0]      addr_q,    addr_d;
    logic [7:0]      data_q,    data_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RW-1:0]   rd_cnt_q,  rd_cnt_d;
    logic            err_chk_q, err_chk_d;
    logic            err_tmo_q, err_tmo_d;
    logic            rx_drop_q, rx_drop_d;

    logic            w_resp_load;
    logic            w_resp_len4;
    logic [3:0][7:0] w_resp_bytes;
    logic            w_resp_done;
    logic            w_chk_ok;

    assign w_chk_ok = (bus.rx_data == frame_chk(cmd_q, addr_q, data_q)) &&
                      ((cmd_q == CMD_WR) || (cmd_q == CMD_RD));

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        data_d       = data_q;
        tmo_cnt_d    = tmo_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        err_chk_d    = 1'b0;
        err_tmo_d    = 1'b0;
        w_resp_load  = 1'b0;
        w_resp_len4  = 1'b0;
        w_resp_bytes = {24'h0, NAK_BYTE};
        rx_drop_d    = bus.rx_valid &&
                       ((state_q == ST_EXEC) || (state_q == ST_RD_WAIT) || (state_q == ST_TX));

        unique case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = ST_GET_CMD;
                end
            end
            ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
                // Expiry wins over a byte landing on the same cycle; the byte is lost.
                if (tmo_cnt_q == c_tmo_max) begin
                    state_d   = ST_IDLE;
                    err_tmo_d = 1'b1;
                    tmo_cnt_d = '0;
                end else if (bus.rx_valid) begin
                    tmo_cnt_d = '0;
                    case (state_q)
                        ST_GET_CMD: begin
                            cmd_d   = bus.rx_data;
                            state_d = ST_GET_ADDR;
                        end
                        ST_GET_ADDR: begin
                            addr_d  = bus.rx_data;
                            state_d = ST_GET_DATA;
                        end
                        ST_GET_DATA: begin
                            data_d  = bus.rx_data;
                            state_d = ST_GET_CHK;
                        end
                        default: begin
                            if (w_chk_ok) begin
                                state_d = ST_EXEC;
                            end else begin
                                err_chk_d   = 1'b1;
                                w_resp_load = 1'b1;
                                state_d     = ST_TX;
                            end
                        end
                    endcase
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                if (cmd_q == CMD_WR) begin
                    w_resp_load  = 1'b1;
                    w_resp_bytes = {24'h0, ACK_BYTE};
                    state_d      = ST_TX;
                end else begin
                    rd_cnt_d = '0;
                    state_d  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.reg_rd_valid) begin
                    w_resp_load  = 1'b1;
                    w_resp_len4  = 1'b1;
                    w_resp_bytes = {addr_q ^ bus.reg_rdata, bus.reg_rdata, addr_q, SYNC_BYTE};
                    state_d      = ST_TX;
                end else if (rd_cnt_q == c_rd_last) begin
                    err_tmo_d   = 1'b1;
                    w_resp_load = 1'b1;
                    state_d     = ST_TX;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            ST_TX: begin
                if (w_resp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            tmo_cnt_q <= '0;
            rd_cnt_q  <= '0;
            err_chk_q <= 1'b0;
            err_tmo_q <= 1'b0;
            rx_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tmo_cnt_q <= tmo_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_chk_q <= err_chk_d;
            err_tmo_q <= err_tmo_d;
            rx_drop_q <= rx_drop_d;
        end
    end

    assign bus.reg_wr_en   = (state_q == ST_EXEC) && (cmd_q == CMD_WR);
    assign bus.reg_rd_en   = (state_q == ST_EXEC) && (cmd_q == CMD_RD);
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = data_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.err_chk     = err_chk_q;
    assign bus.err_timeout = err_tmo_q;
    assign bus.rx_drop     = rx_drop_q;

    uart_resp_seq u_resp_seq (
        .clk        (clk),
        .rst        (rst),
        .load       (w_resp_load),
        .load_len4  (w_resp_len4),
        .load_bytes (w_resp_bytes),
        .tx_ready   (bus.tx_ready),
        .tx_valid   (bus.tx_valid),
        .tx_data    (bus.tx_data),
        .done       (w_resp_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Brief    : Randomized self-checking bench for uart_frame_ctrl against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;
    import uart_pkg::*;

    localparam int TMO   = 60;
    localparam int RDTMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_frame_ctrl_if bus ();

    uart_frame_ctrl #(
        .TIMEOUT_CYC (TMO),
        .RD_TIMEOUT  (RDTMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- observation of DUT outputs ----------------
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         wr_n, rd_n, chk_n, tmo_n, drop_n;
    int         wr_cyc, rd_cyc, chk_seen_cyc, tmo_cyc, busy_fall_cyc;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic       prev_hold = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_rst  = 1'b1;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (prev_hold && !prev_rst) begin
            check_eq("tx_valid_held", bus.tx_valid, 1);
            check_eq("tx_data_stable", bus.tx_data, prev_data);
        end
        if (bus.tx_valid && bus.tx_ready) begin
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
        end
        if (bus.reg_wr_en) begin wr_n++; wr_cyc = cyc; wr_addr = bus.reg_addr; wr_data = bus.reg_wdata; end
        if (bus.reg_rd_en) begin rd_n++; rd_cyc = cyc; rd_addr = bus.reg_addr; end
        if (bus.err_chk)     begin chk_n++; chk_seen_cyc = cyc; end
        if (bus.err_timeout) begin tmo_n++; tmo_cyc = cyc; end
        if (bus.rx_drop)     drop_n++;
        if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
        prev_hold = bus.tx_valid && !bus.tx_ready;
        prev_data = bus.tx_data;
        prev_busy = bus.busy;
        prev_rst  = rst;
    end

    task automatic clear_log();
        tx_log.delete(); tx_cyc.delete();
        wr_n = 0; rd_n = 0; chk_n = 0; tmo_n = 0; drop_n = 0;
        wr_cyc = -1; rd_cyc = -1; chk_seen_cyc = -1; tmo_cyc = -1; busy_fall_cyc = -1;
    endtask

    // ---------------- register bank and transmitter stand-ins ----------------
    int         rd_lat  = 1;
    logic [7:0] rd_val  = 8'h00;
    int         rdy_mode = 0;

    initial begin
        bus.reg_rd_valid = 1'b0;
        bus.reg_rdata    = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.reg_rd_en && rd_lat <= RDTMO) begin
                repeat (rd_lat) @(posedge clk);
                #1;
                bus.reg_rd_valid = 1'b1;
                bus.reg_rdata    = rd_val;
                @(posedge clk);
                #1;
                bus.reg_rd_valid = 1'b0;
                bus.reg_rdata    = 8'($urandom);
            end
        end
    end

    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic idle_gap(input int min_g, input int max_g);
        repeat ($urandom_range(max_g, min_g)) tick();
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                              input logic [7:0] chk, input int min_g, input int max_g,
                              output int chk_cyc);
        send_byte(SYNC_BYTE);
        idle_gap(min_g, max_g); send_byte(cmd);
        idle_gap(min_g, max_g); send_byte(addr);
        idle_gap(min_g, max_g); send_byte(data);
        idle_gap(min_g, max_g);
        chk_cyc = cyc;
        send_byte(chk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) tick();
        check_eq("idle_reached", bus.busy, 0);
        repeat (3) tick();
    endtask

    // Frame-level reference: expected strobes and response from the frame contents.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                             input logic [7:0] chk, input int lat, input logic [7:0] rval,
                             input int min_g, input int max_g, input bit inject);
        logic [7:0] exp_q[$];
        int  e_wr, e_rd, e_chk, e_tmo, chk_cyc;
        bit  ok;
        rd_lat = lat;
        rd_val = rval;
        send_frame(cmd, addr, data, chk, min_g, max_g, chk_cyc);
        if (inject) begin
            for (int i = 0; i < 60 && !bus.tx_valid; i++) tick();
            check_eq("tx_valid_before_drop", bus.tx_valid, 1);
            send_byte(8'($urandom));
        end
        wait_idle();

        e_wr = 0; e_rd = 0; e_chk = 0; e_tmo = 0;
        ok = (chk == (cmd ^ addr ^ data)) && (cmd == 8'h01 || cmd == 8'h02);
        if (!ok) begin
            e_chk = 1; exp_q = {8'h15};
        end else if (cmd == 8'h01) begin
            e_wr = 1; exp_q = {8'h06};
        end else begin
            e_rd = 1;
            if (lat <= RDTMO) exp_q = {8'hA5, addr, rval, addr ^ rval};
            else begin e_tmo = 1; exp_q = {8'h15}; end
        end

        check_eq("wr_strobes", wr_n, e_wr);
        check_eq("rd_strobes", rd_n, e_rd);
        check_eq("err_chk_pulses", chk_n, e_chk);
        check_eq("err_timeout_pulses", tmo_n, e_tmo);
        check_eq("rx_drop_pulses", drop_n, inject ? 1 : 0);
        check_eq("tx_len", tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check_eq($sformatf("tx_byte%0d", i), tx_log[i], exp_q[i]);
        if (e_wr != 0) begin
            check_eq("wr_addr", wr_addr, addr);
            check_eq("wr_data", wr_data, data);
            check_eq("wr_cycle", wr_cyc, chk_cyc + 1);
        end
        if (e_rd != 0) begin
            check_eq("rd_addr", rd_addr, addr);
            check_eq("rd_cycle", rd_cyc, chk_cyc + 1);
        end
        if (e_chk != 0) check_eq("err_chk_cycle", chk_seen_cyc, chk_cyc + 1);
        if (e_tmo != 0) check_eq("rd_timeout_cycle", tmo_cyc, chk_cyc + 2 + RDTMO);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [7:0] cmd, addr, data, chk, g;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        clear_log();

        // Reset state
        repeat (4) tick();
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_tx_valid", bus.tx_valid, 0);
        check_eq("rst_strobes", {bus.reg_wr_en, bus.reg_rd_en}, 0);
        check_eq("rst_errs", {bus.err_chk, bus.err_timeout, bus.rx_drop}, 0);
        check_eq("rst_addr_data", {bus.reg_addr, bus.reg_wdata, bus.tx_data}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Directed write
        clear_log(); rdy_mode = 0;
        run_frame(8'h01, 8'h10, 8'h5A, 8'h4B, 1, 0, 0, 0, 1'b0);
        if (tx_cyc.size() == 1) check_eq("wr_busy_fall", busy_fall_cyc, tx_cyc[0] + 1);

        // Directed read, back-to-back response bytes
        clear_log();
        run_frame(8'h02, 8'h22, 8'h00, 8'h20, 3, 8'h7E, 0, 2, 1'b0);
        if (tx_cyc.size() == 4) check_eq("rd_burst_span", tx_cyc[3] - tx_cyc[0], 3);

        // Garbage before SYNC, then bad checksum
        clear_log();
        send_byte(8'h33); send_byte(8'h44);
        run_frame(8'h01, 8'h10, 8'h5A, 8'h00, 1, 0, 0, 1, 1'b0);

        // Inter-byte timeout, then a normal frame
        clear_log();
        send_byte(SYNC_BYTE);
        c0 = cyc;
        send_byte(8'h01);
        repeat (TMO + 6) tick();
        check_eq("tmo_pulses", tmo_n, 1);
        check_eq("tmo_cycle", tmo_cyc, c0 + TMO + 2);
        check_eq("tmo_no_tx", tx_log.size(), 0);
        check_eq("tmo_busy", bus.busy, 0);
        clear_log();
        run_frame(8'h01, 8'h31, 8'hC4, 8'h01 ^ 8'h31 ^ 8'hC4, 1, 0, 0, 2, 1'b0);

        // Longest legal gap is accepted
        clear_log();
        run_frame(8'h01, 8'h07, 8'h70, 8'h76, 1, 0, TMO - 1, TMO - 1, 1'b0);

        // Byte landing on the expiry cycle is lost, and is not an rx_drop
        clear_log();
        send_byte(SYNC_BYTE);
        repeat (TMO) tick();
        send_byte(8'h01);
        repeat (3) tick();
        check_eq("edge_tmo_pulses", tmo_n, 1);
        check_eq("edge_tmo_busy", bus.busy, 0);
        check_eq("edge_tmo_drops", drop_n, 0);

        // Read at the latency limit, read that never returns, with backpressure and a drop
        clear_log(); rdy_mode = 1;
        run_frame(8'h02, 8'h5C, 8'h99, 8'h02 ^ 8'h5C ^ 8'h99, RDTMO, 8'hE1, 0, 1, 1'b0);
        clear_log();
        run_frame(8'h02, 8'h40, 8'h00, 8'h42, RDTMO + 5, 8'h00, 0, 1, 1'b1);

        // Reset while the second response byte is on offer
        clear_log(); rdy_mode = 0; rd_lat = 2; rd_val = 8'hC3;
        send_frame(8'h02, 8'h44, 8'h11, 8'h57, 0, 0, c0);
        for (int i = 0; i < 60 && !bus.tx_valid; i++) tick();
        check_eq("mid_tx_reached", bus.tx_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        check_eq("mrst_tx_valid", bus.tx_valid, 0);
        check_eq("mrst_busy", bus.busy, 0);
        check_eq("mrst_outs", {bus.reg_addr, bus.tx_data, bus.reg_wr_en, bus.reg_rd_en,
                               bus.err_chk, bus.err_timeout, bus.rx_drop}, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        check_eq("mrst_tx_count", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            check_eq("mrst_tx0", tx_log[0], 8'hA5);
            check_eq("mrst_tx1", tx_log[1], 8'h44);
        end

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            int r;
            clear_log();
            rdy_mode = $urandom_range(0, 2);
            r = $urandom_range(0, 7);
            cmd  = (r < 3) ? 8'h01 : (r < 6) ? 8'h02 : 8'($urandom);
            addr = 8'($urandom);
            data = 8'($urandom);
            chk  = cmd ^ addr ^ data;
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == SYNC_BYTE) g = 8'h5A;
                send_byte(g);
            end
            run_frame(cmd, addr, data, chk, $urandom_range(1, RDTMO + 3), 8'($urandom),
                      0, 3, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
